// File: rtl/spi_flash_rd_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// Register map of the SPI controller and APB phase encoding.
package spi_flash_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_ON,
        ST_CFG,
        ST_TX_WR,
        ST_POLL,
        ST_RX_RD,
        ST_OUT,
        ST_CS_OFF
    } state_t;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS,
        PH_GAP1,
        PH_GAP2
    } phase_t;

    localparam logic [3:0] REG_SPCR   = 4'd0;
    localparam logic [3:0] REG_SPSR   = 4'd1;
    localparam logic [3:0] REG_DATA   = 4'd2;
    localparam logic [3:0] REG_SOFTCS = 4'd5;

    localparam logic [7:0] READ_OP   = 8'h03;
    localparam logic [2:0] HDR_BYTES = 3'd4;

    function automatic logic [3:0] cs_mask(input int sel);
        return 4'(1 << sel);
    endfunction

    function automatic logic [7:0] hdr_byte(
        input logic [2:0]  idx,
        input logic [23:0] addr
    );
        logic [7:0] b;
        b = 8'h00;
        unique case (idx)
            3'd0:    b = READ_OP;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_apb_xfer.sv
// Single APB transfer engine: SETUP, ACCESS, two GAP cycles.
// A held start in GAP2 chains the next transfer without an idle cycle.
module spi_apb_xfer
    import spi_flash_rd_pkg::*;
(
    input  logic       apb_pclk,
    input  logic       apb_prst,
    input  logic       start,
    input  logic       write,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       m_psel,
    output logic       m_penable,
    output logic       m_pwrite,
    output logic [3:0] m_paddr,
    output logic [7:0] m_pwdata,
    input  logic [7:0] m_prdata
);

    phase_t     phase;
    phase_t     phase_nxt;
    logic       launch;
    logic       active;
    logic       write_q;
    logic [3:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;

    assign launch = start
                  && (phase == PH_IDLE || phase == PH_GAP2);

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            phase   <= PH_IDLE;
            write_q <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
        end else begin
            phase <= phase_nxt;
            if (launch) begin
                write_q <= write;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (phase == PH_ACCESS) begin
                rdata_q <= m_prdata;
            end
        end
    end

    always_comb begin
        phase_nxt = phase;
        unique case (phase)
            PH_IDLE:   phase_nxt = launch ? PH_SETUP : PH_IDLE;
            PH_SETUP:  phase_nxt = PH_ACCESS;
            PH_ACCESS: phase_nxt = PH_GAP1;
            PH_GAP1:   phase_nxt = PH_GAP2;
            PH_GAP2:   phase_nxt = launch ? PH_SETUP : PH_IDLE;
            default:   phase_nxt = PH_IDLE;
        endcase
    end

    always_comb begin
        active    = (phase == PH_SETUP) || (phase == PH_ACCESS);
        m_psel    = active;
        m_penable = (phase == PH_ACCESS);
        m_pwrite  = active && write_q;
        m_paddr   = active ? addr_q : 4'd0;
        m_pwdata  = active ? wdata_q : 8'd0;
        done      = (phase == PH_GAP1);
        rdata     = rdata_q;
    end

endmodule

// File: rtl/spi_flash_rd.sv
// SPI flash READ sequencer driving an APB SPI controller one byte
// at a time and streaming the received data bytes out.
module spi_flash_rd
    import spi_flash_rd_pkg::*;
#(
    parameter int         CS_SEL   = 1,
    parameter logic [7:0] SPCR_VAL = 8'h50,
    parameter int         POLL_MAX = 1023
) (
    input  logic        apb_pclk,
    input  logic        apb_prst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic        busy,
    output logic        err,
    output logic        m_psel,
    output logic        m_penable,
    output logic        m_pwrite,
    output logic [3:0]  m_paddr,
    output logic [7:0]  m_pwdata,
    input  logic [7:0]  m_prdata
);

    localparam int PCW = $clog2(POLL_MAX + 1) + 1;
    localparam logic [3:0] CS_M = cs_mask(CS_SEL);
    localparam logic [7:0] CS_ON_VAL  = {~CS_M, CS_M};
    localparam logic [7:0] CS_OFF_VAL = {4'hF, CS_M};

    state_t           state;
    state_t           state_nxt;
    logic [23:0]      addr_q;
    logic [8:0]       cnt;
    logic [2:0]       hdr_cnt;
    logic [PCW-1:0]   poll_cnt;
    logic             poll_full;
    logic             x_start;
    logic             x_write;
    logic [3:0]       x_addr;
    logic [7:0]       x_wdata;
    logic             x_done;
    logic [7:0]       x_rdata;
    logic [7:0]       cur_byte;

    spi_apb_xfer u_xfer (
        .apb_pclk  (apb_pclk),
        .apb_prst  (apb_prst),
        .start     (x_start),
        .write     (x_write),
        .addr      (x_addr),
        .wdata     (x_wdata),
        .done      (x_done),
        .rdata     (x_rdata),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

    assign poll_full = (poll_cnt >= PCW'(POLL_MAX));
    assign cur_byte  = hdr_byte(hdr_cnt, addr_q);

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            addr_q   <= 24'd0;
            cnt      <= 9'd0;
            hdr_cnt  <= 3'd0;
            poll_cnt <= '0;
            rd_data  <= 8'd0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == ST_IDLE && req_valid) begin
                addr_q   <= req_addr;
                cnt      <= (req_len == 8'd0) ? 9'd256
                                              : {1'b0, req_len};
                hdr_cnt  <= 3'd0;
                poll_cnt <= '0;
            end
            if (state == ST_POLL && x_done) begin
                if (!x_rdata[0]) begin
                    poll_cnt <= '0;
                end else begin
                    poll_cnt <= poll_cnt + PCW'(1);
                    err      <= poll_full;
                end
            end
            if (state == ST_RX_RD && x_done) begin
                if (hdr_cnt != HDR_BYTES) begin
                    hdr_cnt <= hdr_cnt + 3'd1;
                end else begin
                    rd_data <= x_rdata;
                end
            end
            if (state == ST_OUT && rd_ready) begin
                cnt <= cnt - 9'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (req_valid) state_nxt = ST_CS_ON;
            ST_CS_ON:
                if (x_done) state_nxt = ST_CFG;
            ST_CFG:
                if (x_done) state_nxt = ST_TX_WR;
            ST_TX_WR:
                if (x_done) state_nxt = ST_POLL;
            ST_POLL:
                if (x_done) begin
                    if (!x_rdata[0])   state_nxt = ST_RX_RD;
                    else if (poll_full) state_nxt = ST_CS_OFF;
                end
            ST_RX_RD:
                if (x_done) begin
                    state_nxt = (hdr_cnt != HDR_BYTES)
                              ? ST_TX_WR : ST_OUT;
                end
            ST_OUT:
                if (rd_ready) begin
                    state_nxt = (cnt == 9'd1)
                              ? ST_CS_OFF : ST_TX_WR;
                end
            ST_CS_OFF:
                if (x_done) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        x_start   = 1'b0;
        x_write   = 1'b0;
        x_addr    = 4'd0;
        x_wdata   = 8'd0;
        req_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        rd_valid  = (state == ST_OUT);
        rd_last   = (state == ST_OUT) && (cnt == 9'd1);
        unique case (state)
            ST_CS_ON: begin
                x_start = 1'b1;
                x_write = 1'b1;
                x_addr  = REG_SOFTCS;
                x_wdata = CS_ON_VAL;
            end
            ST_CFG: begin
                x_start = 1'b1;
                x_write = 1'b1;
                x_addr  = REG_SPCR;
                x_wdata = SPCR_VAL;
            end
            ST_TX_WR: begin
                x_start = 1'b1;
                x_write = 1'b1;
                x_addr  = REG_DATA;
                x_wdata = cur_byte;
            end
            ST_POLL: begin
                x_start = 1'b1;
                x_addr  = REG_SPSR;
            end
            ST_RX_RD: begin
                x_start = 1'b1;
                x_addr  = REG_DATA;
            end
            ST_CS_OFF: begin
                x_start = 1'b1;
                x_write = 1'b1;
                x_addr  = REG_SOFTCS;
                x_wdata = CS_OFF_VAL;
            end
            default: begin
                x_start = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_rd.sv
// Bench: sequencer + behavioural SPI controller + flash (byte[i]=i^A5).
// Expected byte streams come from the flash rule, not from the RTL.
module tb_spi_flash_rd;
    import spi_flash_rd_pkg::*;

    localparam int CS_SEL = 1;
    localparam int DLY    = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = 24'd0;
    logic [7:0]  req_len = 8'd0;
    logic        rd_valid;
    logic        rd_ready = 1'b1;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic        busy;
    logic        err;
    logic        m_psel;
    logic        m_penable;
    logic        m_pwrite;
    logic [3:0]  m_paddr;
    logic [7:0]  m_pwdata;
    logic [7:0]  m_prdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    spi_flash_rd #(
        .CS_SEL   (CS_SEL),
        .SPCR_VAL (8'h50),
        .POLL_MAX (15)
    ) dut (
        .apb_pclk  (clk),
        .apb_prst  (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .err       (err),
        .m_psel    (m_psel),
        .m_penable (m_penable),
        .m_pwrite  (m_pwrite),
        .m_paddr   (m_paddr),
        .m_pwdata  (m_pwdata),
        .m_prdata  (m_prdata)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, act, req);
    endtask

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // ---------------- SPI controller + flash model ----------------
    logic        spe;
    logic        spe_kill = 1'b0;
    logic [7:0]  softcs;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic        rx_full;
    int          busy_cnt;
    int          fk;
    logic [23:0] faddr;
    logic [7:0]  cs_log[$];

    assign m_prdata =
        (m_psel && m_paddr == REG_SPSR) ? {7'd0, !rx_full} :
        (m_psel && m_paddr == REG_DATA) ? rx_byte : 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            spe      <= 1'b0;
            softcs   <= 8'hF0;
            rx_full  <= 1'b0;
            rx_byte  <= 8'h00;
            tx_byte  <= 8'h00;
            busy_cnt <= 0;
            fk       <= 0;
            faddr    <= 24'd0;
        end else begin
            if (m_psel && m_penable && m_pwrite) begin
                case (m_paddr)
                    REG_SPCR: spe <= m_pwdata[6] && !spe_kill;
                    REG_DATA: begin
                        check("fifo_occupancy",
                              {30'd0, rx_full, busy_cnt != 0}, 0);
                        if (spe) begin
                            busy_cnt <= DLY;
                            tx_byte  <= m_pwdata;
                        end
                    end
                    REG_SOFTCS: begin
                        softcs <= m_pwdata;
                        cs_log.push_back(m_pwdata);
                        if (!m_pwdata[4+CS_SEL]) fk <= 0;
                    end
                    default: ;
                endcase
            end
            if (m_psel && m_penable && !m_pwrite
                && m_paddr == REG_DATA)
                rx_full <= 1'b0;
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    rx_full <= 1'b1;
                    fk      <= fk + 1;
                    if (fk == 0) check("opcode", tx_byte, 8'h03);
                    if (fk >= 1 && fk <= 3)
                        faddr <= {faddr[15:0], tx_byte};
                    rx_byte <= (fk < 4) ? 8'hFF
                             : flash_byte(faddr + 24'(fk - 4));
                end
            end
        end
    end

    // ---------------- APB protocol monitor ----------------
    int         xfers = 0;
    int         poll_reads = 0;
    int         gap_cnt = 99;
    int         err_seen = 0;
    logic       err_prev = 1'b0;
    logic       s_w;
    logic [3:0] s_a;
    logic [7:0] s_d;

    always @(negedge clk) begin
        if (rst) begin
            gap_cnt  = 99;
            err_prev = 1'b0;
        end else begin
            if (m_psel && !m_penable) begin
                check("apb_gap", gap_cnt >= 2, 1);
                xfers++;
                s_w = m_pwrite;
                s_a = m_paddr;
                s_d = m_pwdata;
                if (m_pwrite && m_paddr == REG_DATA) poll_reads = 0;
                if (!m_pwrite && m_paddr == REG_SPSR) poll_reads++;
                gap_cnt = 0;
            end else if (m_psel && m_penable) begin
                check("apb_hold", {m_pwrite, m_paddr, m_pwdata},
                      {s_w, s_a, s_d});
            end else begin
                check("apb_idle_zero",
                      {m_penable, m_pwrite, m_paddr, m_pwdata}, 0);
                gap_cnt++;
            end
            if (err) begin
                check("err_polls", poll_reads, 16);
                check("err_pulse", err_prev, 0);
                err_seen++;
            end
            err_prev = err;
        end
    end

    // ---------------- read-stream compare ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         last_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rd_valid", 1, 0);
                end else begin
                    check("rd_data", rd_data, exp_q[0]);
                    check("rd_last", rd_last, exp_q.size() == 1);
                    if (rd_ready) begin
                        got_q.push_back(rd_data);
                        void'(exp_q.pop_front());
                        if (rd_last) last_cnt++;
                    end
                end
            end else begin
                check("rd_last_idle", rd_last, 0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input logic [23:0] a,
                          input logic [7:0] l,
                          input bit expect_data);
        int n;
        int t;
        t = 0;
        while (!req_ready && t < 2000) begin
            step();
            t++;
        end
        check("req_ready_wait", t < 2000, 1);
        n = (l == 8'd0) ? 256 : int'(l);
        if (expect_data)
            for (int i = 0; i < n; i++)
                exp_q.push_back(flash_byte(a + 24'(i)));
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int t;
        t = 0;
        while (!(exp_q.size() == 0 && req_ready) && t < budget) begin
            step();
            t++;
        end
        check(name, t < budget, 1);
    endtask

    task automatic rst_checks(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_rd"}, {rd_valid, rd_last, rd_data}, 0);
        check({tag, "_busy_err"}, {busy, err}, 0);
        check({tag, "_apb"},
              {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 0);
    endtask

    function automatic logic [31:0] pack4(input int base);
        logic [31:0] w;
        w = 32'hDEADDEAD;
        if (got_q.size() >= base + 4)
            w = {got_q[base], got_q[base+1],
                 got_q[base+2], got_q[base+3]};
        return w;
    endfunction

    initial begin
        int t;
        int x0;
        repeat (3) step();
        #1;
        rst_checks("reset");
        rst = 1'b0;
        step();

        // basic 4-byte read
        cs_log.delete();
        got_q.delete();
        last_cnt = 0;
        do_req(24'h000010, 8'd4, 1);
        wait_done("t1_done", 3000);
        check("t1_bytes", pack4(0), 32'hB5B4B7B6);
        check("t1_last_cnt", last_cnt, 1);
        check("t1_cs_log_n", cs_log.size(), 2);
        check("t1_cs_on", cs_log.size() > 0 ? cs_log[0] : 8'h0,
              8'hD2);
        check("t1_cs_off", cs_log.size() > 1 ? cs_log[1] : 8'h0,
              8'hF2);

        // 256-byte read with a request ignored while busy
        got_q.delete();
        last_cnt = 0;
        do_req(24'hFFFF00, 8'd0, 1);
        repeat (20) step();
        check("t2_busy", busy, 1);
        req_valid = 1'b1;
        req_addr  = 24'h000777;
        req_len   = 8'd5;
        repeat (5) step();
        req_valid = 1'b0;
        wait_done("t2_done", 30000);
        repeat (100) step();
        check("t2_count", got_q.size(), 256);
        check("t2_first", got_q.size() > 0 ? got_q[0] : 8'h0,
              8'hA5);
        check("t2_final", got_q.size() == 256 ? got_q[255] : 8'h0,
              8'h5A);
        check("t2_last_cnt", last_cnt, 1);
        check("t2_idle", {busy, req_ready}, 2'b01);

        // consumer stall on the first byte
        got_q.delete();
        rd_ready = 1'b0;
        do_req(24'h000123, 8'd2, 1);
        t = 0;
        while (!rd_valid && t < 2000) begin
            step();
            t++;
        end
        check("t3_rd_valid_wait", t < 2000, 1);
        x0 = xfers;
        repeat (50) step();
        check("t3_stall_xfers", xfers - x0, 0);
        check("t3_still_valid", rd_valid, 1);
        rd_ready = 1'b1;
        wait_done("t3_done", 3000);
        check("t3_bytes", {got_q.size() > 0 ? got_q[0] : 8'h0,
                           got_q.size() > 1 ? got_q[1] : 8'h0},
              16'h8681);

        // controller never completes -> poll timeout
        spe_kill = 1'b1;
        cs_log.delete();
        err_seen = 0;
        do_req(24'h000040, 8'd3, 0);
        t = 0;
        while (!(err_seen > 0 && req_ready) && t < 3000) begin
            step();
            t++;
        end
        check("t4_timeout_wait", t < 3000, 1);
        check("t4_err_seen", err_seen, 1);
        check("t4_cs_log_n", cs_log.size(), 2);
        check("t4_cs_off",
              cs_log.size() > 0 ? cs_log[cs_log.size()-1] : 8'h0,
              8'hF2);
        spe_kill = 1'b0;

        // reset while polling, then a clean request
        do_req(24'h000080, 8'd3, 1);
        t = 0;
        while (!(m_psel && !m_pwrite && m_paddr == REG_SPSR)
               && t < 2000) begin
            step();
            t++;
        end
        check("t5_poll_wait", t < 2000, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst_checks("t5_abort");
        exp_q.delete();
        step();
        rst = 1'b0;
        got_q.delete();
        do_req(24'h000200, 8'd3, 1);
        wait_done("t5_done", 3000);
        check("t5_bytes", {8'h00, got_q.size() > 0 ? got_q[0] : 8'h0,
                           got_q.size() > 1 ? got_q[1] : 8'h0,
                           got_q.size() > 2 ? got_q[2] : 8'h0},
              32'h00A5A4A7);

        repeat (10) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
